// File: rtl/h264_bit_packer.sv
// ---------------------------------------------------------------------------
// h264_bit_packer
//
// Bitstream packer placed after the CAVLC encoder. Variable-length codes
// (0..CODE_W bits, MSB-aligned) arrive over a valid/ready handshake. They are
// concatenated MSB-first into OUT_W-bit words, and the words are stored in a
// DEPTH-entry buffer. The bus side reads that buffer through a registered
// read port.
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   in_valid    a code is present on in_code/in_len
//   in_ready    the packer accepts a code this cycle
//   in_code     code bits, first emitted bit is in_code[CODE_W-1]
//   in_len      code length 0..CODE_W
//   flush       pulse: pad pending bits with zeros and emit them as a word
//   buf_clear   reset the buffer word count to zero
//   rd_addr     buffer read address
//   rd_data     registered buffer word at rd_addr
//   buf_cnt     number of valid words in the buffer, 0..DEPTH
//   buf_full    buf_cnt == DEPTH
//   busy        packer is shifting or flushing, or a flush is pending
//   total_bits  bits accepted since reset, wraps modulo 2^32
// ---------------------------------------------------------------------------
module h264_bit_packer #(
    parameter int CODE_W = 128,
    parameter int LEN_W  = $clog2(CODE_W + 1),
    parameter int OUT_W  = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic [LEN_W-1:0]  in_len,
    input  logic              flush,
    input  logic              buf_clear,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [OUT_W-1:0]  rd_data,
    output logic [ADDR_W:0]   buf_cnt,
    output logic              buf_full,
    output logic              busy,
    output logic [31:0]       total_bits
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    localparam int FILL_W = $clog2(OUT_W + 1);
    localparam int K_W    = (LEN_W > FILL_W) ? LEN_W : FILL_W;
    localparam logic [K_W-1:0]    OUT_W_K = K_W'(OUT_W);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W + 1)'(1);

    logic [1:0]               state;
    logic [CODE_W-1:0]        sr;
    logic [LEN_W-1:0]         rem;
    logic [OUT_W-1:0]         acc;
    logic [FILL_W-1:0]        acc_bits;
    logic                     flush_pending;
    logic [OUT_W-1:0]         mem [DEPTH];

    logic                     accept;
    logic                     blocked;
    logic [K_W-1:0]           room;
    logic [K_W-1:0]           rem_k;
    logic [K_W-1:0]           take;
    logic [K_W-1:0]           fill_sum;
    logic                     completes;
    logic [CODE_W+OUT_W-1:0]  sr_ext;
    logic [OUT_W-1:0]         window;
    logic [OUT_W-1:0]         head_mask;
    logic [OUT_W-1:0]         merged;
    logic                     wr_en;
    logic [OUT_W-1:0]         wr_data;
    logic [ADDR_W-1:0]        wr_addr;

    assign in_ready = (state == IDLE) & ~flush_pending & ~rst;
    assign accept   = in_valid & in_ready;
    assign buf_full = (buf_cnt == DEPTH_C);
    assign busy     = (state != IDLE) | flush_pending;
    // A clear in the same cycle frees address 0, so a full buffer only blocks
    // a write when no clear is present.
    assign blocked  = buf_full & ~buf_clear;

    // One shift step. The accumulator is kept MSB-aligned and is zero below
    // its fill level. The top 'take' bits of sr are masked and slid down
    // under the bits that are already held. The {sr, zeros} extension also
    // covers codes that are narrower than a word.
    always_comb begin
        room      = OUT_W_K - K_W'(acc_bits);
        rem_k     = K_W'(rem);
        take      = (rem_k < room) ? rem_k : room;
        fill_sum  = K_W'(acc_bits) + take;
        completes = (fill_sum == OUT_W_K);
        sr_ext    = {sr, {OUT_W{1'b0}}};
        window    = OUT_W'(sr_ext >> CODE_W);
        head_mask = ~({OUT_W{1'b1}} >> take);
        merged    = acc | ((window & head_mask) >> acc_bits);
    end

    // Buffer write selection. A completed word comes from SHIFT, and a
    // zero-padded partial word comes from FLUSH. A clear redirects the write
    // to address 0.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = merged;
        if (!rst && state == SHIFT && completes && !blocked) begin
            wr_en = 1'b1;
        end else if (!rst && state == FLUSH && acc_bits != '0 && !blocked) begin
            wr_en   = 1'b1;
            wr_data = acc;
        end
        wr_addr = buf_clear ? '0 : buf_cnt[ADDR_W-1:0];
    end

    // Main control: handshake, shifting, flush servicing and buffer count.
    // A stalled SHIFT or FLUSH cycle leaves every field unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            sr            <= '0;
            rem           <= '0;
            acc           <= '0;
            acc_bits      <= '0;
            flush_pending <= 1'b0;
            buf_cnt       <= '0;
            total_bits    <= '0;
            rd_data       <= '0;
        end else begin
            rd_data <= mem[rd_addr];

            if (flush) begin
                flush_pending <= 1'b1;
            end

            if (buf_clear) begin
                buf_cnt <= {{ADDR_W{1'b0}}, wr_en};
            end else if (wr_en) begin
                buf_cnt <= buf_cnt + ONE_C;
            end

            case (state)
                IDLE: begin
                    if (accept && in_len != '0) begin
                        sr         <= in_code;
                        rem        <= in_len;
                        total_bits <= total_bits + 32'(in_len);
                        state      <= SHIFT;
                    end else if (flush_pending || flush) begin
                        state <= FLUSH;
                    end
                end
                SHIFT: begin
                    if (!(completes && blocked)) begin
                        sr  <= sr << take;
                        rem <= rem - LEN_W'(take);
                        if (completes) begin
                            acc      <= '0;
                            acc_bits <= '0;
                        end else begin
                            acc      <= merged;
                            acc_bits <= FILL_W'(fill_sum);
                        end
                        if (rem_k == take) begin
                            state <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    if (acc_bits == '0 || !blocked) begin
                        acc      <= '0;
                        acc_bits <= '0;
                        state    <= IDLE;
                        if (!flush) begin
                            flush_pending <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Word storage. The memory has no reset, and a clear leaves its old
    // contents in place.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_h264_bit_packer.sv
// ---------------------------------------------------------------------------
// tb_h264_bit_packer
//
// Bench for h264_bit_packer with a small buffer, so that back-pressure occurs.
// The reference model keeps a plain queue of pending bits. Every complete
// word, and every zero-padded flush word, is pushed into an expected-word
// queue.
//
// A monitor process drains the buffer through the read port and clears it
// once every stored word has been read. Each word it reads is compared
// against the head of the expected-word queue.
// ---------------------------------------------------------------------------
module tb_h264_bit_packer;

    localparam int CODE_W = 128;
    localparam int LEN_W  = 8;
    localparam int OUT_W  = 32;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_code;
    logic [LEN_W-1:0]  in_len;
    logic              flush;
    logic              buf_clear;
    logic [ADDR_W-1:0] rd_addr;
    logic [OUT_W-1:0]  rd_data;
    logic [ADDR_W:0]   buf_cnt;
    logic              buf_full;
    logic              busy;
    logic [31:0]       total_bits;

    int errors = 0;
    int checks = 0;

    logic [OUT_W-1:0] exp_q[$];
    bit               mbits[$];
    logic [31:0]      mtotal = '0;
    bit               hold_reads = 1'b0;

    h264_bit_packer #(
        .CODE_W(CODE_W),
        .LEN_W (LEN_W),
        .OUT_W (OUT_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_len    (in_len),
        .flush     (flush),
        .buf_clear (buf_clear),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .buf_cnt   (buf_cnt),
        .buf_full  (buf_full),
        .busy      (busy),
        .total_bits(total_bits)
    );

    always #5 clk = ~clk;

    // Reference model: an MSB-first bit queue that is cut into words.
    function automatic void model_pack();
        while (mbits.size() >= OUT_W) begin
            logic [OUT_W-1:0] w;
            w = '0;
            for (int i = 0; i < OUT_W; i++) begin
                w[OUT_W-1-i] = mbits.pop_front();
            end
            exp_q.push_back(w);
        end
    endfunction

    function automatic void model_accept(input logic [CODE_W-1:0] code, input int len);
        for (int i = 0; i < len; i++) begin
            mbits.push_back(code[CODE_W-1-i]);
        end
        mtotal += 32'(len);
        model_pack();
    endfunction

    function automatic void model_flush();
        if (mbits.size() > 0) begin
            while (mbits.size() < OUT_W) begin
                mbits.push_back(1'b0);
            end
        end
        model_pack();
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [CODE_W-1:0] code, input int len, input bit fl);
        int n;
        n = 0;
        while (!in_ready && n < 500) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL in_ready_timeout: got in_ready=0 after %0d cycles, expected 1", n);
            return;
        end
        in_valid = 1'b1;
        in_code  = code;
        in_len   = LEN_W'(len);
        flush    = fl;
        model_accept(code, len);
        if (fl) model_flush();
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic applyFlush();
        flush = 1'b1;
        model_flush();
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 500) begin
            tick();
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_idle_timeout: got busy=1, expected 0", name);
        end
    endtask

    task automatic drain(input string name);
        int n;
        wait_idle(name);
        n = 0;
        while ((exp_q.size() != 0 || buf_cnt != '0) && n < 500) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0 || buf_cnt != '0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_drain_timeout: got %0d words outstanding, buf_cnt=%0d, expected 0",
                     name, exp_q.size(), buf_cnt);
        end
    endtask

    function automatic logic [CODE_W-1:0] rand_code();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Monitor: reads each stored word, compares it with the scoreboard, and
    // clears the buffer once every stored word has been read.
    initial begin
        int rp;
        bit pend;
        rp        = 0;
        pend      = 1'b0;
        buf_clear = 1'b0;
        rd_addr   = '0;
        forever begin
            @(negedge clk);
            buf_clear = 1'b0;
            if (rst) begin
                rp   = 0;
                pend = 1'b0;
            end else if (!hold_reads) begin
                if (pend) begin
                    pend = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_word: got 0x%0h, expected no word", rd_data);
                    end else begin
                        checkOutput("buffer_word", rd_data, exp_q.pop_front());
                    end
                    rp++;
                end
                if (rp > 0 && rp == int'(buf_cnt)) begin
                    buf_clear = 1'b1;
                    rp        = 0;
                end else if (int'(buf_cnt) > rp) begin
                    rd_addr = ADDR_W'(rp);
                    pend    = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, expected $finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int n;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_code  = '0;
        in_len   = '0;
        flush    = 1'b0;

        // Reset state.
        tick(); tick(); tick();
        checkOutput("rst_in_ready",   in_ready,   0);
        checkOutput("rst_buf_cnt",    buf_cnt,    0);
        checkOutput("rst_buf_full",   buf_full,   0);
        checkOutput("rst_busy",       busy,       0);
        checkOutput("rst_total_bits", total_bits, 0);
        checkOutput("rst_rd_data",    rd_data,    0);
        rst = 1'b0;
        tick();
        checkOutput("post_rst_in_ready", in_ready, 1);

        // Two 16-bit codes form one word.
        applyStimulus({16'hABCD, 112'b0}, 16, 1'b0);
        applyStimulus({16'h1234, 112'b0}, 16, 1'b0);
        drain("t1");
        checkOutput("t1_total_bits", total_bits, 32);

        // A 100-bit code from an empty accumulator.
        hold_reads = 1'b1;
        applyStimulus(rand_code(), 100, 1'b0);
        lat = 0;
        while (!in_ready && lat < 50) begin
            tick();
            lat++;
        end
        checkOutput("t2_ready_latency", lat, 4);
        checkOutput("t2_buf_cnt", buf_cnt, 3);
        checkOutput("t2_total_bits", total_bits, 132);
        hold_reads = 1'b0;
        drain("t2");

        // Flush the 4 leftover bits, then a 5-bit code plus flush, then an
        // empty flush.
        applyFlush();
        drain("t3a");
        hold_reads = 1'b1;
        applyStimulus({5'b10110, 123'b0}, 5, 1'b0);
        wait_idle("t3b");
        applyFlush();
        wait_idle("t3c");
        checkOutput("t3_buf_cnt_flush", buf_cnt, 1);
        applyFlush();
        wait_idle("t3d");
        checkOutput("t3_buf_cnt_empty_flush", buf_cnt, 1);
        hold_reads = 1'b0;
        drain("t3");

        // Fill the buffer; the fifth word stalls until the buffer is cleared.
        hold_reads = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(rand_code(), 32, 1'b0);
        end
        tick(); tick();
        checkOutput("t4_buf_full", buf_full, 1);
        checkOutput("t4_busy",     busy,     1);
        checkOutput("t4_in_ready", in_ready, 0);
        checkOutput("t4_buf_cnt",  buf_cnt,  4);
        hold_reads = 1'b0;
        n = 0;
        while (buf_full && n < 50) begin
            tick();
            n++;
        end
        checkOutput("t4_buf_full_after_clear", buf_full, 0);
        checkOutput("t4_buf_cnt_after_clear",  buf_cnt,  1);
        drain("t4");

        // A zero-length code changes nothing.
        applyStimulus(rand_code(), 0, 1'b0);
        checkOutput("t5_len0_busy",     busy,       0);
        checkOutput("t5_len0_in_ready", in_ready,   1);
        checkOutput("t5_len0_total",    total_bits, mtotal);

        // A flush during SHIFT is serviced after the code completes.
        applyStimulus(rand_code(), 40, 1'b0);
        applyFlush();
        checkOutput("t5_flush_busy",     busy,     1);
        checkOutput("t5_flush_in_ready", in_ready, 0);
        drain("t5");

        // Reset in the middle of a 96-bit code.
        hold_reads = 1'b1;
        applyStimulus(rand_code(), 96, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        checkOutput("t6_buf_cnt",    buf_cnt,    0);
        checkOutput("t6_total_bits", total_bits, 0);
        checkOutput("t6_in_ready",   in_ready,   0);
        checkOutput("t6_busy",       busy,       0);
        exp_q.delete();
        mbits.delete();
        mtotal = '0;
        rst = 1'b0;
        hold_reads = 1'b0;
        tick();
        checkOutput("t6_in_ready_after", in_ready, 1);

        // Random traffic with occasional flushes and idle gaps.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(rand_code(), int'($urandom_range(0, CODE_W)),
                          ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) tick();
        end
        applyFlush();
        drain("rand");
        checkOutput("rand_total_bits", total_bits, mtotal);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/h264_bit_packer.md
# h264_bit_packer

Parametrised bitstream packer sitting after the CAVLC encoder in the H264 encoder pipeline. It accepts variable-length codes (0..CODE_W bits, MSB-first) over a valid/ready handshake, concatenates them into OUT_W-bit words, and stores the words in a DEPTH-entry output buffer. The bus side reads the buffer through a registered read port, with word-count, full and clear controls. Over a fixed 128-bit/32-bit packer it adds generic widths and depth, back-pressure on a full buffer, a zero-padding flush to the word boundary, and a running bit counter.

## Interface
- CODE_W, 128, maximum code length in bits; code bus width
- LEN_W, $clog2(CODE_W+1), width of the length field
- OUT_W, 32, packed word width; must divide CODE_W... not required, any OUT_W ≥ 8
- DEPTH, 64, buffer depth in words (power of two)
- ADDR_W, $clog2(DEPTH), buffer address width
- One clock; reset is synchronous and active-high:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  code present
- in_ready  out  1  packer accepts code this cycle
- in_code  in  CODE_W  code, MSB-aligned: first emitted bit is in_code[CODE_W-1]
- in_len  in  LEN_W  code length 0..CODE_W; values >CODE_W are illegal
- flush  in  1  pulse: pad pending bits with zeros and emit as one word
- buf_clear  in  1  reset buffer word count to 0
- rd_addr  in  ADDR_W  buffer read address
- rd_data  out  OUT_W  registered buffer word at rd_addr
- buf_cnt  out  ADDR_W+1  valid words in buffer, 0..DEPTH
- buf_full  out  1  buf_cnt == DEPTH
- busy  out  1  state != IDLE or flush pending
- total_bits  out  32  bits accepted since reset, wraps modulo 2^32

## Operation
- States: IDLE, SHIFT, FLUSH. Internal: shift register sr[CODE_W], remaining count rem, accumulator acc[OUT_W] with fill acc_bits 0..OUT_W-1, flush_pending flag.
- in_ready = (state==IDLE) & ~flush_pending & ~rst.
- Handshake: in_valid & in_ready. len>0: sr←in_code, rem←in_len, total_bits += in_len, → SHIFT. len=0: accepted, discarded, stays IDLE, total_bits unchanged.
- SHIFT, per cycle: k = min(rem, OUT_W−acc_bits). Top k bits of sr appended below existing acc bits; sr shifts left k; rem −= k. If acc_bits+k == OUT_W, word written to mem[wr_addr], acc_bits←0; else acc_bits += k. rem reaching 0 → IDLE.
- Stall: a cycle whose transfer would complete a word while buf_full (and no buf_clear) transfers nothing; state held.
- wr_addr = buf_cnt (0 if buf_clear same cycle). Write increments buf_cnt.
- flush sets flush_pending in any state; serviced from IDLE → FLUSH. FLUSH: acc_bits>0 → write {acc bits, zeros} as one word, acc_bits←0 (stalls while full); acc_bits==0 → no write. Clears flush_pending, → IDLE.
- buf_clear: buf_cnt←0 (plus 1 if a word is written that same cycle, at address 0). Accumulator, sr, state unaffected. Memory contents not cleared.
- Read: rd_data ← mem[rd_addr] every cycle; contents at addresses ≥ buf_cnt are unspecified.
- Memory is not reset.

## Timing
- Reset: state IDLE, acc_bits 0, rem 0, flush_pending 0, buf_cnt 0, buf_full 0, busy 0, total_bits 0, rd_data 0, in_ready 0 while rst high. Reset mid-SHIFT/FLUSH discards partial code and accumulator bits.
- Code of length L accepted at cycle t with fill a: SHIFT occupies t+1..t+n, n = 1 if L ≤ OUT_W−a, else 1 + ceil((L−(OUT_W−a))/OUT_W), plus stall cycles; in_ready high again at t+n+1.
- buf_cnt/buf_full update the cycle after the write edge; rd_data valid one cycle after rd_addr.
- Flush from IDLE: FLUSH next cycle, IDLE the cycle after.

## Test plan
- OUT_W=32: codes (len 16, 0xABCD) then (len 16, 0x1234) → mem[0]=0xABCD1234, buf_cnt=1, acc_bits 0, total_bits 32.
- Single len-100 code from empty accumulator → 4 SHIFT cycles, 3 words written, acc_bits 4, buf_cnt 3, in_ready returns 5 cycles after accept.
- len 5 code 5'b10110 then flush → mem[0]=0xB0000000, buf_cnt 1; second flush with empty accumulator → no write, buf_cnt stays 1.
- DEPTH=4: fill 4 words, 5th word completion stalls (buf_full=1, busy=1, in_ready=0); pulse buf_clear → stalled word written to address 0, buf_cnt 1, buf_full 0.
- len-0 code accepted → no state change, total_bits unchanged; flush asserted during SHIFT is serviced after the code completes.
- rst asserted mid-SHIFT of a len-96 code → next cycle buf_cnt 0, total_bits 0, acc_bits 0, in_ready 1 after rst drops.
